// File: rtl/lc3_alu_sequencer_pkg.sv
// Shared constants for the LC-3 operate-instruction sequencer: ALU/IR opcodes, FSM states, NZP helper.
// The optional MOV decode is enabled by defining LC3_SEQ_MOV_EN (see lc3_alu_sequencer.sv).
package lc3_alu_sequencer_pkg;

    localparam int LC3_NREGS = 8;
    localparam int LC3_DW    = 16;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_AND   = 2'b01,
        ALU_NOT   = 2'b10,
        ALU_PASS1 = 2'b11
    } alu_op_e;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_MOV = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_e;

    localparam logic [2:0] NZP_RESET = 3'b010;

    function automatic logic [2:0] nzp_of(input logic [LC3_DW-1:0] value);
        if (value[LC3_DW-1]) begin
            return 3'b100;
        end else if (value == '0) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

endpackage

// File: rtl/lc3_alu_sequencer_if.sv
// Instruction-fetch handshake into the sequencer: fetch side is master, sequencer is slave.
interface lc3_alu_sequencer_if #(
    parameter int DW = lc3_alu_sequencer_pkg::LC3_DW
);
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/lc3_alu_sequencer_regfile.sv
// LC-3 general-purpose register file: two combinational read ports, a debug read port,
// one synchronous write port and a synchronous clear.
module lc3_regfile
    import lc3_alu_sequencer_pkg::*;
#(
    parameter int NREGS = LC3_NREGS,
    parameter int DW    = LC3_DW,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata1_o,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata2_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = regs_q[raddr1_i];
    assign rdata2_o   = regs_q[raddr2_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/lc3_alu_sequencer.sv
// Four-state controller (IDLE/READ/EXEC/WB) driving an external combinational LC-3 ALU.
// Define LC3_SEQ_MOV_EN to decode opcode 1101 as MOV DR,SR1; otherwise 1101 retires as illegal.
module lc3_alu_sequencer
    import lc3_alu_sequencer_pkg::*;
#(
    parameter int NREGS = LC3_NREGS,
    parameter int DW    = LC3_DW
) (
    input  logic                clk,
    input  logic                rst,
    lc3_alu_sequencer_if.slave  instr_if,
    output logic [4:0]          alu_operand1,
    output logic [DW-1:0]       alu_operand2,
    output logic [DW-1:0]       alu_operand0,
    output logic                alu_sr2mux,
    output logic [1:0]          alu_opcode,
    input  logic [DW-1:0]       alu_result,
    output logic                done,
    output logic                illegal,
    output logic [2:0]          nzp,
    input  logic [2:0]          dbg_addr,
    output logic [DW-1:0]       dbg_data
);

    state_e        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [4:0]    op1_q, op1_d;
    logic [DW-1:0] op2_q, op2_d;
    logic [DW-1:0] op0_q, op0_d;
    logic          sr2mux_q, sr2mux_d;
    alu_op_e       aluop_q, aluop_d;
    logic          illegal_q, illegal_d;
    logic [2:0]    nzp_q, nzp_d;

    logic [DW-1:0] sr1_val;
    logic [DW-1:0] sr2_val;
    logic          rf_we;
    logic          ready;
    logic [3:0]    opc;

    assign opc = ir_q[15:12];

    lc3_regfile #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .raddr1_i   (ir_q[8:6]),
        .rdata1_o   (sr1_val),
        .raddr2_i   (ir_q[2:0]),
        .rdata2_o   (sr2_val),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (rf_we),
        .waddr_i    (ir_q[11:9]),
        .wdata_i    (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            op0_q     <= '0;
            sr2mux_q  <= 1'b0;
            aluop_q   <= ALU_ADD;
            illegal_q <= 1'b0;
            nzp_q     <= NZP_RESET;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            op0_q     <= op0_d;
            sr2mux_q  <= sr2mux_d;
            aluop_q   <= aluop_d;
            illegal_q <= illegal_d;
            nzp_q     <= nzp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        op0_d     = op0_q;
        sr2mux_d  = sr2mux_q;
        aluop_d   = aluop_q;
        illegal_d = illegal_q;
        nzp_d     = nzp_q;
        rf_we     = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (instr_if.instr_valid) begin
                    ir_d    = instr_if.instr;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d   = S_EXEC;
                illegal_d = 1'b0;
                case (opc)
                    OP_ADD, OP_AND: begin
                        aluop_d  = (opc == OP_ADD) ? ALU_ADD : ALU_AND;
                        op2_d    = sr1_val;
                        op0_d    = sr2_val;
                        sr2mux_d = ir_q[5];
                    end
                    // The ALU inverts the SR2MUX path, so SR1 is routed onto operand0.
                    OP_NOT: begin
                        aluop_d  = ALU_NOT;
                        op2_d    = sr1_val;
                        op0_d    = sr1_val;
                        sr2mux_d = 1'b0;
                    end
                    OP_MOV: begin
`ifdef LC3_SEQ_MOV_EN
                        aluop_d  = ALU_PASS1;
                        op2_d    = sr1_val;
                        op0_d    = sr2_val;
                        sr2mux_d = 1'b0;
`else
                        illegal_d = 1'b1;
                        state_d   = S_WB;
`endif
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_WB;
                    end
                endcase
                if (!illegal_d) begin
                    op1_d = ir_q[4:0];
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                done    = 1'b1;
                illegal = illegal_q;
                if (!illegal_q) begin
                    rf_we = 1'b1;
                    nzp_d = nzp_of(alu_result);
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset landing in WB must not retire or write the abandoned instruction.
        if (rst) begin
            done    = 1'b0;
            illegal = 1'b0;
            rf_we   = 1'b0;
        end
    end

    assign instr_if.instr_ready = ready;
    assign alu_operand1         = op1_q;
    assign alu_operand2         = op2_q;
    assign alu_operand0         = op0_q;
    assign alu_sr2mux           = sr2mux_q;
    assign alu_opcode           = aluop_q;
    assign nzp                  = nzp_q;

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Scoreboard bench for lc3_alu_sequencer with a behavioural LC-3 ALU in the loop.
module tb_lc3_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [4:0]  alu_operand1;
    logic [15:0] alu_operand2;
    logic [15:0] alu_operand0;
    logic        alu_sr2mux;
    logic [1:0]  alu_opcode;
    logic [15:0] alu_result;
    logic        done;
    logic        illegal;
    logic [2:0]  nzp;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic        ill;
        logic [2:0]  dr;
        logic [15:0] val;
        logic [2:0]  nzp;
        logic [1:0]  opc;
        logic        sr2;
        logic [4:0]  op1;
        int          t;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc3_alu_sequencer_if #(.DW(16)) bus ();
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = instr;
    assign instr_ready     = bus.instr_ready;

    lc3_alu_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_if     (bus),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_operand0 (alu_operand0),
        .alu_sr2mux   (alu_sr2mux),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .done         (done),
        .illegal      (illegal),
        .nzp          (nzp),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Combinational LC-3 ALU as seen by the sequencer.
    logic [15:0] mux_v;
    always_comb begin
        mux_v = alu_sr2mux ? {{11{alu_operand1[4]}}, alu_operand1} : alu_operand0;
        case (alu_opcode)
            2'b00:   alu_result = alu_operand2 + mux_v;
            2'b01:   alu_result = alu_operand2 & mux_v;
            2'b10:   alu_result = ~mux_v;
            default: alu_result = alu_operand2;
        endcase
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_op(input logic [15:0] w, input logic ill, input logic [15:0] val,
                                      input logic [2:0] nz, input logic [1:0] opc, input logic sr2);
        exp_t e;
        e.ill = ill; e.dr = w[11:9]; e.val = val; e.nzp = nz;
        e.opc = opc; e.sr2 = sr2; e.op1 = w[4:0]; e.t = cyc;
        sb_q.push_back(e);
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("ready_timeout", {31'b0, instr_ready}, 32'd1);
    endtask

    task automatic send(input logic [15:0] w, input logic ill, input logic [15:0] val,
                        input logic [2:0] nz, input logic [1:0] opc, input logic sr2);
        wait_ready();
        expect_op(w, ill, val, nz, opc, sr2);
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops one expectation per done pulse; checks WB-cycle outputs, then post-WB state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {31'b0, done}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("latency", cyc - e.t, e.ill ? 32'd2 : 32'd3);
                    chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
                    if (!e.ill) begin
                        chk("alu_opcode", {30'b0, alu_opcode}, {30'b0, e.opc});
                        chk("alu_sr2mux", {31'b0, alu_sr2mux}, {31'b0, e.sr2});
                        chk("alu_operand1", {27'b0, alu_operand1}, {27'b0, e.op1});
                        chk("alu_result", {16'b0, alu_result}, {16'b0, e.val});
                    end
                    dbg_addr = e.dr;
                    @(posedge clk);
                    #1;
                    $display("txn dr=R%0d value=%04h nzp=%03b illegal=%0b", e.dr, dbg_data, nzp, e.ill);
                    chk("reg_value", {16'b0, dbg_data}, {16'b0, e.val});
                    chk("nzp", {29'b0, nzp}, {29'b0, e.nzp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset_ready", {31'b0, instr_ready}, 32'd1);
        chk("reset_nzp", {29'b0, nzp}, 32'd2);
        chk("reset_done", {30'b0, done, illegal}, 32'd0);
        chk("reset_alu", {alu_operand2, alu_operand0[7:0], alu_operand1, alu_sr2mux, alu_opcode}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            chk("reset_reg", {16'b0, dbg_data}, 32'd0);
        end

        // ADD with immediates, including a negative imm5
        send(16'h1225, 1'b0, 16'h0005, 3'b001, 2'b00, 1'b1);   // ADD R1,R0,#5
        send(16'h147D, 1'b0, 16'h0002, 3'b001, 2'b00, 1'b1);   // ADD R2,R1,#-3

        // Build R1 = 0x00F0 and R3 = 0x0F0F, then AND / NOT
        send(16'h122F, 1'b0, 16'h000F, 3'b001, 2'b00, 1'b1);   // ADD R1,R0,#15
        send(16'h1241, 1'b0, 16'h001E, 3'b001, 2'b00, 1'b0);   // ADD R1,R1,R1
        send(16'h1241, 1'b0, 16'h003C, 3'b001, 2'b00, 1'b0);
        send(16'h1241, 1'b0, 16'h0078, 3'b001, 2'b00, 1'b0);
        send(16'h1241, 1'b0, 16'h00F0, 3'b001, 2'b00, 1'b0);
        send(16'h1660, 1'b0, 16'h00F0, 3'b001, 2'b00, 1'b1);   // ADD R3,R1,#0
        send(16'h16C3, 1'b0, 16'h01E0, 3'b001, 2'b00, 1'b0);   // ADD R3,R3,R3
        send(16'h16C3, 1'b0, 16'h03C0, 3'b001, 2'b00, 1'b0);
        send(16'h16C3, 1'b0, 16'h0780, 3'b001, 2'b00, 1'b0);
        send(16'h16C3, 1'b0, 16'h0F00, 3'b001, 2'b00, 1'b0);
        send(16'h16EF, 1'b0, 16'h0F0F, 3'b001, 2'b00, 1'b1);   // ADD R3,R3,#15
        send(16'h5843, 1'b0, 16'h0000, 3'b010, 2'b01, 1'b0);   // AND R4,R1,R3
        send(16'h9B3F, 1'b0, 16'hFFFF, 3'b100, 2'b10, 1'b0);   // NOT R5,R4

        // R6 = 0x7FFF via doubling and NOT, then wrap with DR == SR1
        send(16'h1D21, 1'b0, 16'h0001, 3'b001, 2'b00, 1'b1);   // ADD R6,R4,#1
        for (int i = 1; i < 16; i++) begin
            send(16'h1D86, 1'b0, 16'(1 << i), (i == 15) ? 3'b100 : 3'b001, 2'b00, 1'b0);
        end
        send(16'h9DBF, 1'b0, 16'h7FFF, 3'b001, 2'b10, 1'b0);   // NOT R6,R6
        send(16'h1DA1, 1'b0, 16'h8000, 3'b100, 2'b00, 1'b1);   // ADD R6,R6,#1

        // Illegal opcodes leave registers and nzp alone
        send(16'hF025, 1'b1, 16'h0000, 3'b100, 2'b00, 1'b0);
`ifdef LC3_SEQ_MOV_EN
        send(16'hD283, 1'b0, 16'h0002, 3'b001, 2'b11, 1'b0);   // MOV R1,R2
`else
        send(16'hD283, 1'b1, 16'h00F0, 3'b100, 2'b00, 1'b0);
`endif
        drain();

        // instr_valid held for 8 cycles: accepts only at offsets 0 and 4
        wait_ready();
        instr       = 16'h1E23;                                 // ADD R7,R0,#3
        instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ready_pattern", {31'b0, instr_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
            if (instr_ready) begin
                if (i == 0) expect_op(16'h1E23, 1'b0, 16'h0003, 3'b001, 2'b00, 1'b1);
                else        expect_op(16'h1FFF, 1'b0, 16'h0002, 3'b001, 2'b00, 1'b1);
            end
            @(negedge clk);
            if (i == 0) instr = 16'h1FFF;                        // ADD R7,R7,#-1
        end
        instr_valid = 1'b0;
        drain();

        // Reset during EXEC abandons the instruction
        wait_ready();
        instr       = 16'h1FE5;                                 // ADD R7,R7,#5
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", {31'b0, instr_ready}, 32'd1);
        chk("rst_mid_nzp", {29'b0, nzp}, 32'd2);
        dbg_addr = 3'd7;
        #1;
        chk("rst_mid_r7", {16'b0, dbg_data}, 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("rst_mid_no_done", n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
